pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Consumer side of the load-use stall request: converts the hazard detector's `StallReq` level, plus branch flush and data-memory busy, into pipeline control. It owns the IF/ID pipeline register and the PC write enable, and inserts bubbles into ID/EX. A bounded-stall watchdog guarantees forward progress. It sits between the IF and ID stages of the 5-stage MIPS core.

## Interface
- `MAX_STALL`, default 2: maximum consecutive load-use stall cycles before a forced one-cycle release; legal range 1..15.
- `Clk` input 1: rising-edge clock.
- `Reset` input 1: reset, synchronous, active-low.
- `StallReq` input 1: load-use hazard request, level, from the hazard detector.
- `FlushReq` input 1: branch/jump taken in EX; squash the instruction in IF.
- `MemBusy` input 1: data memory not ready; freeze the whole pipeline.
- `Instr_IF` input 32: fetched instruction.
- `PC4_IF` input 32: PC+4 of the fetched instruction.
- `Instr_ID` output 32: IF/ID instruction register.
- `PC4_ID` output 32: IF/ID PC+4 register.
- `Valid_ID` output 1: IF/ID holds a real instruction.
- `PCWrite` output 1: PC register load enable.
- `Bubble_EX` output 1: force zero control signals into ID/EX this cycle.
- `FreezeAll` output 1: hold ID/EX, EX/MEM and MEM/WB registers this cycle.
- `StallCount` output 16: only present with `STALL_PERF_CNT_EN`; cumulative stall cycles.

## Operation
- FSM states: RUN, STALL, MEMWAIT, RELEASE. Reset state is RUN.
- Per-cycle action priority, highest first: Reset low, MemBusy, FlushReq, StallReq (unless the state is RELEASE), then normal.
- **Reset low:** at the edge, Instr_ID=0, PC4_ID=0, Valid_ID=0, state=RUN, stall counter=0. Combinational outputs while Reset is low: PCWrite=0, Bubble_EX=1, FreezeAll=0.
- **MemBusy=1, any state:**
  - PCWrite=0, FreezeAll=1, Bubble_EX=0.
  - IF/ID holds.
  - Next state is MEMWAIT; the stall counter holds.
  - From MEMWAIT with MemBusy=0, evaluate the remaining rules as if in RUN.
- **FlushReq=1:**
  - PCWrite=1 (the target mux is external), Bubble_EX=1.
  - At the edge, Instr_ID=0 (nop), Valid_ID=0, PC4_ID=PC4_IF.
  - Stall counter cleared; next state RUN.
- **StallReq=1 and state is not RELEASE:**
  - PCWrite=0, Bubble_EX=1.
  - IF/ID holds.
  - Stall counter increments.
  - If the incremented count equals MAX_STALL, next state is RELEASE. Otherwise next state is STALL.
- **Normal (RUN, STALL with StallReq=0, or RELEASE):**
  - PCWrite=1, Bubble_EX=0.
  - At the edge, IF/ID loads Instr_IF and PC4_IF, and Valid_ID=1.
  - Stall counter cleared; next state RUN.
  - In RELEASE, StallReq is ignored for exactly one cycle.
- The stall counter is 4 bits and never exceeds MAX_STALL.

## Timing
- PCWrite, Bubble_EX and FreezeAll are combinational from the state and the current-cycle inputs. There is zero latency from a StallReq edge to PCWrite=0.
- IF/ID updates are visible one cycle after the enabling cycle.
- A load-use hazard held for one cycle costs exactly one bubble. A hazard held continuously costs MAX_STALL bubbles, then one forced advance, and the sequence repeats.
- Simultaneous FlushReq and StallReq: flush wins; no bubble is repeated the next cycle unless StallReq is still high.
- MemBusy asserted mid-STALL: the stall count is preserved and resumes after MemBusy drops.
- Reset low in any state overrides all other inputs in that same cycle.

## Configuration
- `STALL_PERF_CNT_EN` defined:
  - Adds the `StallCount` port: a 16-bit counter that increments on every cycle with StallReq-caused stalls or MemBusy freezes.
  - The counter saturates at 16'hFFFF and clears to 0 on Reset low.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset:** Reset=0 for 2 cycles with Instr_IF=32'h8C220004 -> Instr_ID=0, Valid_ID=0, PCWrite=0, Bubble_EX=1. Release Reset -> next edge Instr_ID=32'h8C220004, Valid_ID=1.
- **Single load-use:** StallReq=1 for one cycle -> that cycle PCWrite=0, Bubble_EX=1, Instr_ID unchanged. Next cycle PCWrite=1 and IF/ID advances.
- **Watchdog:** MAX_STALL=2, StallReq held high for 6 cycles -> PCWrite pattern 0,0,1,0,0,1.
- **Flush priority:** FlushReq=1 and StallReq=1 together -> PCWrite=1, Bubble_EX=1. Next edge Instr_ID=0, Valid_ID=0.
- **Memory freeze:** MemBusy=1 for 3 cycles during STALL (count 1) -> FreezeAll=1, PCWrite=0, Bubble_EX=0, IF/ID held. After release with StallReq=1 and MAX_STALL=2 -> one more stall, then RELEASE.
- **Perf counter (`STALL_PERF_CNT_EN`):**
  - 3 stall cycles plus 2 MemBusy cycles -> StallCount=5.
  - Counter preloaded near saturation via a long stall -> StallCount holds at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// IF/ID register owner and load-use stall / flush / memory-freeze controller with a
// bounded-stall watchdog. Define STALL_PERF_CNT_EN to add the StallCount perf counter.
module pipeline_stall_controller #(
  parameter int unsigned MAX_STALL = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StallReq,
  input  logic        FlushReq,
  input  logic        MemBusy,
  input  logic [31:0] Instr_IF,
  input  logic [31:0] PC4_IF,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC4_ID,
  output logic        Valid_ID,
  output logic        PCWrite,
  output logic        Bubble_EX,
  output logic        FreezeAll
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [15:0] StallCount
`endif
);

  typedef enum logic [1:0] {RUN, STALL, MEMWAIT, RELEASE} state_e;

  localparam logic [4:0] MAX_S = 5'(MAX_STALL);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [4:0]  cnt_inc;
  logic        stall_cyc;

  // One bit wider so MAX_STALL=15 cannot wrap the comparison.
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    PCWrite   = 1'b1;
    Bubble_EX = 1'b0;
    FreezeAll = 1'b0;
    stall_cyc = 1'b0;
    if (!Reset) begin
      PCWrite   = 1'b0;
      Bubble_EX = 1'b1;
    end else if (MemBusy) begin
      PCWrite   = 1'b0;
      FreezeAll = 1'b1;
      stall_cyc = 1'b1;
      state_d   = MEMWAIT;
    end else if (FlushReq) begin
      Bubble_EX = 1'b1;
      instr_d   = 32'h0;
      valid_d   = 1'b0;
      pc4_d     = PC4_IF;
      cnt_d     = 4'd0;
      state_d   = RUN;
    end else if (StallReq && state_q != RELEASE) begin
      PCWrite   = 1'b0;
      Bubble_EX = 1'b1;
      stall_cyc = 1'b1;
      // >= with clamp: a freeze taken in RELEASE leaves the count at MAX_STALL.
      if (cnt_inc >= MAX_S) begin
        cnt_d   = MAX_S[3:0];
        state_d = RELEASE;
      end else begin
        cnt_d   = cnt_inc[3:0];
        state_d = STALL;
      end
    end else begin
      instr_d = Instr_IF;
      pc4_d   = PC4_IF;
      valid_d = 1'b1;
      cnt_d   = 4'd0;
      state_d = RUN;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign Instr_ID = instr_q;
  assign PC4_ID   = pc4_q;
  assign Valid_ID = valid_q;

`ifdef STALL_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall_cyc && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) perf_q <= 16'h0;
    else        perf_q <= perf_d;
  end

  assign StallCount = perf_q;
`else
  logic unused_stall_cyc;
  assign unused_stall_cyc = stall_cyc;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed vector table, corner sequences and
// random stimulus against a run-length reference model.
module tb_pipeline_stall_controller;
  localparam int MAXS = 2;

  logic        Clk = 1'b0;
  logic        Reset, StallReq, FlushReq, MemBusy;
  logic [31:0] Instr_IF, PC4_IF, Instr_ID, PC4_ID;
  logic        Valid_ID, PCWrite, Bubble_EX, FreezeAll;
`ifdef STALL_PERF_CNT_EN
  logic [15:0] StallCount;
`endif

  pipeline_stall_controller #(.MAX_STALL(MAXS)) dut (
    .Clk(Clk), .Reset(Reset), .StallReq(StallReq), .FlushReq(FlushReq),
    .MemBusy(MemBusy), .Instr_IF(Instr_IF), .PC4_IF(PC4_IF),
    .Instr_ID(Instr_ID), .PC4_ID(PC4_ID), .Valid_ID(Valid_ID),
    .PCWrite(PCWrite), .Bubble_EX(Bubble_EX), .FreezeAll(FreezeAll)
`ifdef STALL_PERF_CNT_EN
    , .StallCount(StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model: IF/ID contents, length of the current stall run, and whether
  // the previous cycle ended a watchdog-limited run (forced advance pending).
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  int          m_run;
  bit          m_rel;
  int          m_perf;
  logic        m_pcw, m_bub, m_frz;

  typedef struct {
    bit r, s, f, m;
    logic [31:0] ins, p;
    bit pcw, bub, frz;
    logic [31:0] iid;
    bit vid;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_run = 0; m_rel = 0; m_perf = 0;
  endfunction

  function automatic void model_comb();
    bit stall;
    stall = StallReq && !m_rel;
    if (!Reset)         {m_pcw, m_bub, m_frz} = 3'b010;
    else if (MemBusy)   {m_pcw, m_bub, m_frz} = 3'b001;
    else if (FlushReq)  {m_pcw, m_bub, m_frz} = 3'b110;
    else if (stall)     {m_pcw, m_bub, m_frz} = 3'b010;
    else                {m_pcw, m_bub, m_frz} = 3'b100;
  endfunction

  function automatic void model_edge();
    bit stall;
    stall = StallReq && !m_rel;
    if (!Reset) begin
      model_reset();
    end else begin
      if ((MemBusy || (stall && !FlushReq)) && m_perf < 65535) m_perf++;
      if (MemBusy) begin
        m_rel = 0;
      end else if (FlushReq) begin
        m_instr = 32'h0; m_valid = 1'b0; m_pc4 = PC4_IF; m_run = 0; m_rel = 0;
      end else if (stall) begin
        m_run = m_run + 1;
        m_rel = (m_run >= MAXS);
        if (m_run > MAXS) m_run = MAXS;
      end else begin
        m_instr = Instr_IF; m_pc4 = PC4_IF; m_valid = 1'b1; m_run = 0; m_rel = 0;
      end
    end
  endfunction

  task automatic drive(input bit r, s, f, m, input logic [31:0] ins, p);
    Reset = r; StallReq = s; FlushReq = f; MemBusy = m; Instr_IF = ins; PC4_IF = p;
  endtask

  task automatic check_model();
    model_comb();
    chk("PCWrite", 32'(PCWrite), 32'(m_pcw));
    chk("Bubble_EX", 32'(Bubble_EX), 32'(m_bub));
    chk("FreezeAll", 32'(FreezeAll), 32'(m_frz));
    chk("Instr_ID", Instr_ID, m_instr);
    chk("PC4_ID", PC4_ID, m_pc4);
    chk("Valid_ID", 32'(Valid_ID), 32'(m_valid));
`ifdef STALL_PERF_CNT_EN
    chk("StallCount", 32'(StallCount), 32'(m_perf));
`endif
  endtask

  task automatic finish_cycle();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic apply(input bit r, s, f, m, input logic [31:0] ins, p);
    drive(r, s, f, m, ins, p);
    #3;
    check_model();
    finish_cycle();
  endtask

  initial begin
    tbl[0]  = '{0,0,0,0, 32'h8C220004, 32'h04, 0,1,0, 32'h0,        0};
    tbl[1]  = '{0,0,0,0, 32'h8C220004, 32'h04, 0,1,0, 32'h0,        0};
    tbl[2]  = '{1,0,0,0, 32'h8C220004, 32'h04, 1,0,0, 32'h0,        0};
    tbl[3]  = '{1,1,0,0, 32'hA1,       32'h08, 0,1,0, 32'h8C220004, 1};
    tbl[4]  = '{1,0,0,0, 32'hA1,       32'h08, 1,0,0, 32'h8C220004, 1};
    tbl[5]  = '{1,1,0,0, 32'hA2,       32'h0C, 0,1,0, 32'hA1,       1};
    tbl[6]  = '{1,1,0,0, 32'hA2,       32'h0C, 0,1,0, 32'hA1,       1};
    tbl[7]  = '{1,1,0,0, 32'hA2,       32'h0C, 1,0,0, 32'hA1,       1};
    tbl[8]  = '{1,1,0,0, 32'hA3,       32'h10, 0,1,0, 32'hA2,       1};
    tbl[9]  = '{1,1,0,0, 32'hA3,       32'h10, 0,1,0, 32'hA2,       1};
    tbl[10] = '{1,1,0,0, 32'hA3,       32'h10, 1,0,0, 32'hA2,       1};
    tbl[11] = '{1,1,1,0, 32'hA4,       32'h14, 1,1,0, 32'hA3,       1};
    tbl[12] = '{1,0,0,0, 32'hA4,       32'h14, 1,0,0, 32'h0,        0};
    tbl[13] = '{1,1,0,0, 32'hA5,       32'h18, 0,1,0, 32'hA4,       1};
    tbl[14] = '{1,1,0,1, 32'hA5,       32'h18, 0,0,1, 32'hA4,       1};
    tbl[15] = '{1,1,0,1, 32'hA5,       32'h18, 0,0,1, 32'hA4,       1};
    tbl[16] = '{1,1,0,1, 32'hA5,       32'h18, 0,0,1, 32'hA4,       1};
    tbl[17] = '{1,1,0,0, 32'hA5,       32'h18, 0,1,0, 32'hA4,       1};
    tbl[18] = '{1,1,0,0, 32'hA5,       32'h18, 1,0,0, 32'hA4,       1};
    tbl[19] = '{1,0,0,0, 32'hA6,       32'h1C, 1,0,0, 32'hA5,       1};
    tbl[20] = '{0,1,1,1, 32'hA7,       32'h20, 0,1,0, 32'hA6,       1};
    tbl[21] = '{1,0,0,0, 32'hA7,       32'h20, 1,0,0, 32'h0,        0};

    // Bring registers out of X before any comparison.
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    @(posedge Clk); #1;
    model_reset();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].m, tbl[i].ins, tbl[i].p);
      #3;
      chk($sformatf("vec%0d.PCWrite", i), 32'(PCWrite), 32'(tbl[i].pcw));
      chk($sformatf("vec%0d.Bubble_EX", i), 32'(Bubble_EX), 32'(tbl[i].bub));
      chk($sformatf("vec%0d.FreezeAll", i), 32'(FreezeAll), 32'(tbl[i].frz));
      chk($sformatf("vec%0d.Instr_ID", i), Instr_ID, tbl[i].iid);
      chk($sformatf("vec%0d.Valid_ID", i), 32'(Valid_ID), 32'(tbl[i].vid));
      check_model();
      finish_cycle();
    end

    // Flush with no stall afterwards: no repeated bubble, PC4_ID captured from IF.
    apply(1, 0, 1, 0, 32'hB1, 32'h100);
    drive(1, 0, 0, 0, 32'hB2, 32'h104);
    #3;
    chk("post_flush.Bubble_EX", 32'(Bubble_EX), 32'd0);
    chk("post_flush.PC4_ID", PC4_ID, 32'h100);
    check_model();
    finish_cycle();

`ifdef STALL_PERF_CNT_EN
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    apply(1, 1, 0, 0, 32'hC1, 32'h4);
    apply(1, 1, 0, 0, 32'hC1, 32'h4);
    apply(1, 0, 0, 0, 32'hC1, 32'h4);
    apply(1, 1, 0, 0, 32'hC2, 32'h8);
    apply(1, 0, 0, 1, 32'hC2, 32'h8);
    apply(1, 0, 0, 1, 32'hC2, 32'h8);
    drive(1, 0, 0, 0, 32'hC2, 32'h8);
    #3;
    chk("perf.five", 32'(StallCount), 32'd5);
    finish_cycle();
    drive(1, 0, 0, 1, 32'hC3, 32'hC);
    for (int i = 0; i < 65540; i++) finish_cycle();
    chk("perf.sat", 32'(StallCount), 32'hFFFF);
    finish_cycle();
    chk("perf.sat_hold", 32'(StallCount), 32'hFFFF);
    check_model();
    finish_cycle();
`endif

    for (int i = 0; i < 600; i++) begin
      bit r, s, f, m;
      r = ($urandom_range(0, 99) >= 3);
      s = ($urandom_range(0, 99) < 55);
      f = ($urandom_range(0, 99) < 10);
      m = ($urandom_range(0, 99) < 15);
      apply(r, s, f, m, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
